// File: rtl/tank_level_if.sv
// Bus between the irrigation controller and the tank plant model.
// master: controller side (drives actuators, reads sensors/level/flags).
// slave : tank side (reads actuators, drives sensors/level/flags).
// Optional macro SENSOR_FAULT_INJECT_EN adds the 3-bit sensor_fault signal
// (bit 0 = low, bit 1 = mid, bit 2 = high), driven by the master.
interface tank_level_if #(
  parameter int unsigned LEVEL_W = 8
);
  logic               watter_supply_valvule;
  logic               splinker_bomb;
  logic               dripper_valvule;
  logic               clear_flags;
  logic               low_watter_level;
  logic               mid_watter_level;
  logic               high_watter_level;
  logic [LEVEL_W-1:0] level;
  logic               overflow_flag;
  logic               dry_run_flag;
`ifdef SENSOR_FAULT_INJECT_EN
  logic [2:0]         sensor_fault;

  modport master (
    output watter_supply_valvule, splinker_bomb, dripper_valvule, clear_flags,
    output sensor_fault,
    input  low_watter_level, mid_watter_level, high_watter_level,
    input  level, overflow_flag, dry_run_flag
  );

  modport slave (
    input  watter_supply_valvule, splinker_bomb, dripper_valvule, clear_flags,
    input  sensor_fault,
    output low_watter_level, mid_watter_level, high_watter_level,
    output level, overflow_flag, dry_run_flag
  );
`else
  modport master (
    output watter_supply_valvule, splinker_bomb, dripper_valvule, clear_flags,
    input  low_watter_level, mid_watter_level, high_watter_level,
    input  level, overflow_flag, dry_run_flag
  );

  modport slave (
    input  watter_supply_valvule, splinker_bomb, dripper_valvule, clear_flags,
    output low_watter_level, mid_watter_level, high_watter_level,
    output level, overflow_flag, dry_run_flag
  );
`endif
endinterface

// File: rtl/tank_level_model.sv
// Behavioural water-tank plant. Integrates supply/sprinkler/dripper commands
// into a saturating volume once per prescaler tick and drives low/mid/high
// level sensors plus sticky overflow / dry-run flags back to the controller.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - tank_level_if.slave: actuators + clear_flags in; sensors,
//             level (volume, unregistered copy of vol), sticky flags out
// Optional macro SENSOR_FAULT_INJECT_EN: bus.sensor_fault forces the matching
// sensor output to 0 (stuck dry) after the sensor register.
module tank_level_model #(
  parameter int unsigned LEVEL_W        = 8,
  parameter int unsigned CAPACITY       = 200,
  parameter int unsigned INIT_LEVEL     = 0,
  parameter int unsigned LOW_MARK       = 40,
  parameter int unsigned MID_MARK       = 100,
  parameter int unsigned HIGH_MARK      = 180,
  parameter int unsigned FILL_RATE      = 4,
  parameter int unsigned SPRINKLER_RATE = 3,
  parameter int unsigned DRIPPER_RATE   = 1,
  parameter int unsigned TICK_DIV       = 4
) (
  input logic          clock,
  input logic          reset_n,
  tank_level_if.slave  bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NET_W = LEVEL_W + 2;

  localparam logic INIT_LOW  = (INIT_LEVEL >= LOW_MARK);
  localparam logic INIT_MID  = (INIT_LEVEL >= MID_MARK);
  localparam logic INIT_HIGH = (INIT_LEVEL >= HIGH_MARK);

  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick_c;
  logic [LEVEL_W-1:0]      vol;
  logic [LEVEL_W-1:0]      vol_next_c;
  logic signed [NET_W-1:0] net_c;
  logic                    ovf_set_c;
  logic                    dry_set_c;
  logic                    ovf_q;
  logic                    dry_q;
  logic                    low_q;
  logic                    mid_q;
  logic                    high_q;

  // Prescaler: one update tick every TICK_DIV edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Net volume change, evaluated signed with two guard bits so both
  // overshoot above CAPACITY and undershoot below zero are visible.
  always_comb begin
    tick_c     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    net_c      = signed'({2'b00, vol});
    if (bus.watter_supply_valvule) net_c = net_c + signed'(NET_W'(FILL_RATE));
    if (bus.splinker_bomb)         net_c = net_c - signed'(NET_W'(SPRINKLER_RATE));
    if (bus.dripper_valvule)       net_c = net_c - signed'(NET_W'(DRIPPER_RATE));
    ovf_set_c  = tick_c && (net_c > signed'(NET_W'(CAPACITY)));
    dry_set_c  = tick_c && (net_c < signed'(NET_W'(0)));
    vol_next_c = vol;
    if (ovf_set_c) begin
      vol_next_c = LEVEL_W'(CAPACITY);
    end else if (dry_set_c) begin
      vol_next_c = '0;
    end else if (tick_c) begin
      vol_next_c = LEVEL_W'(net_c);
    end
  end

  // Volume register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vol <= LEVEL_W'(INIT_LEVEL);
    end else begin
      vol <= vol_next_c;
    end
  end

  // Sticky flags; a set on a tick overrides a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      dry_q <= 1'b0;
    end else begin
      if (ovf_set_c)            ovf_q <= 1'b1;
      else if (bus.clear_flags) ovf_q <= 1'b0;
      if (dry_set_c)            dry_q <= 1'b1;
      else if (bus.clear_flags) dry_q <= 1'b0;
    end
  end

  // Level sensors, one cycle behind the volume register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      low_q  <= INIT_LOW;
      mid_q  <= INIT_MID;
      high_q <= INIT_HIGH;
    end else begin
      low_q  <= (vol >= LEVEL_W'(LOW_MARK));
      mid_q  <= (vol >= LEVEL_W'(MID_MARK));
      high_q <= (vol >= LEVEL_W'(HIGH_MARK));
    end
  end

  assign bus.level         = vol;
  assign bus.overflow_flag = ovf_q;
  assign bus.dry_run_flag  = dry_q;

`ifdef SENSOR_FAULT_INJECT_EN
  // Fault mask sits after the register so injection takes effect immediately.
  assign bus.low_watter_level  = low_q  & ~bus.sensor_fault[0];
  assign bus.mid_watter_level  = mid_q  & ~bus.sensor_fault[1];
  assign bus.high_watter_level = high_q & ~bus.sensor_fault[2];
`else
  assign bus.low_watter_level  = low_q;
  assign bus.mid_watter_level  = mid_q;
  assign bus.high_watter_level = high_q;
`endif

endmodule
